// File: rtl/q44_mac_sequencer.sv
// Job-level sequencer for one Q4.4 dot-product neuron: streams operand pairs into a
// Q8.8 accumulator, adds a Q4.4 bias and presents one requantised Q4.4 result.
module q44_mac_sequencer #(
   parameter int LEN_W   = 8,
   parameter bit SAT_ACC = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [7:0]       cfg_bias,
   input  logic             cfg_relu,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [7:0]       op_a,
   input  logic [7:0]       op_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic             res_sat,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      BIAS  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t              state_r;
   logic signed [15:0]  acc_r;
   logic [LEN_W-1:0]    count_r;
   logic [LEN_W-1:0]    len_r;
   logic [7:0]          bias_r;
   logic                relu_r;
   logic                sat_r;

   logic signed [15:0]  a_ext_s;
   logic signed [15:0]  b_ext_s;
   logic signed [15:0]  prod_s;
   logic signed [15:0]  bias_ext_s;
   logic [16:0]         acc_add_s;
   logic [16:0]         bias_add_s;
   logic [8:0]          quant_s;
   logic                last_s;

   // Returns {clamp_flag, sum}; clamps only when SAT_ACC is set.
   function automatic logic [16:0] sat_add(input logic signed [15:0] a, input logic signed [15:0] b);
      logic [16:0] sum;
      logic [16:0] res;
      sum = {a[15], a} + {b[15], b};
      if (SAT_ACC && (sum[16] != sum[15])) begin
         res = sum[16] ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF};
      end else begin
         res = {1'b0, sum[15:0]};
      end
      return res;
   endfunction

   // Returns {sat_flag, q4.4 result}; truncation toward -inf comes from dropping acc[3:0].
   function automatic logic [8:0] requant(input logic signed [15:0] acc, input logic relu);
      logic [8:0] res;
      if (relu) begin
         if (acc < 16'sh0000) begin
            res = {1'b0, 8'h00};
         end else if (acc > 16'sh0FF0) begin
            res = {1'b1, 8'hFF};
         end else begin
            res = {1'b0, acc[11:4]};
         end
      end else begin
         if (acc > 16'sh07F0) begin
            res = {1'b1, 8'h7F};
         end else if (acc < 16'shF800) begin
            res = {1'b1, 8'h80};
         end else begin
            res = {1'b0, acc[11:4]};
         end
      end
      return res;
   endfunction

   assign a_ext_s    = {{8{op_a[7]}}, op_a};
   assign b_ext_s    = {{8{op_b[7]}}, op_b};
   assign prod_s     = a_ext_s * b_ext_s;
   assign bias_ext_s = {{4{bias_r[7]}}, bias_r, 4'b0000};
   assign acc_add_s  = sat_add(acc_r, prod_s);
   assign bias_add_s = sat_add(acc_r, bias_ext_s);
   assign quant_s    = requant(bias_add_s[15:0], relu_r);
   assign last_s     = (count_r == (len_r - LEN_W'(1)));

   // Job FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         acc_r     <= 16'sh0000;
         count_r   <= '0;
         len_r     <= '0;
         bias_r    <= 8'h00;
         relu_r    <= 1'b0;
         sat_r     <= 1'b0;
         op_ready  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= 8'h00;
         res_sat   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  len_r   <= cfg_len;
                  bias_r  <= cfg_bias;
                  relu_r  <= cfg_relu;
                  acc_r   <= 16'sh0000;
                  sat_r   <= 1'b0;
                  count_r <= '0;
                  busy    <= 1'b1;
                  if (cfg_len == '0) begin
                     state_r  <= BIAS;
                     op_ready <= 1'b0;
                  end else begin
                     state_r  <= ACCUM;
                     op_ready <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (op_valid && op_ready) begin
                  acc_r   <= acc_add_s[15:0];
                  sat_r   <= sat_r | acc_add_s[16];
                  count_r <= count_r + LEN_W'(1);
                  if (last_s) begin
                     state_r  <= BIAS;
                     op_ready <= 1'b0;
                  end
               end
            end
            // Bias add and requantisation share one edge so the result lands on OUT entry.
            BIAS: begin
               acc_r     <= bias_add_s[15:0];
               sat_r     <= sat_r | bias_add_s[16];
               res_data  <= quant_s[7:0];
               res_sat   <= sat_r | bias_add_s[16] | quant_s[8];
               res_valid <= 1'b1;
               state_r   <= OUT;
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               op_ready  <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q44_mac_sequencer.sv
// Directed self-checking bench for q44_mac_sequencer; expected values are hand-computed
// from the Q4.4 arithmetic of each job.
module tb_q44_mac_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] cfg_len;
   logic [7:0] cfg_bias;
   logic       cfg_relu;
   logic       op_valid;
   logic       op_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_sat;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   q44_mac_sequencer #(.LEN_W(8), .SAT_ACC(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
      .cfg_relu(cfg_relu), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a),
      .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_sat(res_sat), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [7:0] len, input logic [7:0] bias, input logic relu);
      @(negedge clk);
      start = 1'b1; cfg_len = len; cfg_bias = bias; cfg_relu = relu;
      @(negedge clk);
      start = 1'b0; cfg_len = 8'h00; cfg_bias = 8'h00; cfg_relu = 1'b0;
      check("busy_after_start", {15'd0, busy}, 16'd1);
      check("op_ready_after_start", {15'd0, op_ready}, {15'd0, (len != 8'h00)});
   endtask

   // Offers one pair until it is accepted; noisy mode randomises op_valid and spams start.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic noisy);
      logic hs;
      int   n;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 100) begin
         op_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
         op_a = noisy && !op_valid ? 8'($urandom) : a;
         op_b = noisy && !op_valid ? 8'($urandom) : b;
         if (op_valid) begin
            op_a = a; op_b = b;
         end
         start = noisy; cfg_len = 8'h00; cfg_bias = 8'h7F; cfg_relu = 1'b1;
         hs = op_valid && op_ready;
         n++;
         @(negedge clk);
      end
      op_valid = 1'b0; start = 1'b0; cfg_bias = 8'h00; cfg_relu = 1'b0;
      if (!hs) check("send_timeout", 16'd1, 16'd0);
   endtask

   // Called at the negedge following the last handshake (or the start of an empty job).
   task automatic wait_result(input logic [7:0] exp_data, input logic exp_sat,
                              input int hold, input logic noisy);
      check("op_ready_drop", {15'd0, op_ready}, 16'd0);
      check("res_valid_early", {15'd0, res_valid}, 16'd0);
      @(negedge clk);
      check("res_valid", {15'd0, res_valid}, 16'd1);
      check("res_data", {8'd0, res_data}, {8'd0, exp_data});
      check("res_sat", {15'd0, res_sat}, {15'd0, exp_sat});
      for (int i = 0; i < hold; i++) begin
         start = noisy; cfg_len = 8'h00; cfg_bias = 8'h7F;
         @(negedge clk);
         check("hold_valid", {15'd0, res_valid}, 16'd1);
         check("hold_data", {8'd0, res_data}, {8'd0, exp_data});
         check("hold_busy", {15'd0, busy}, 16'd1);
      end
      res_ready = 1'b1; start = noisy; cfg_len = 8'h00; cfg_bias = 8'h7F;
      @(negedge clk);
      res_ready = 1'b0; start = 1'b0; cfg_bias = 8'h00;
      check("res_valid_clear", {15'd0, res_valid}, 16'd0);
      check("busy_clear", {15'd0, busy}, 16'd0);
      @(negedge clk);
      check("idle_after_hs", {14'd0, busy, res_valid}, 16'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_len = 8'h00; cfg_bias = 8'h00; cfg_relu = 1'b0;
      op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00; res_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {11'd0, op_ready, res_valid, res_sat, busy, 1'b0}, 16'd0);
      check("reset_data", {8'd0, res_data}, 16'd0);
      rst = 1'b0;

      // T1: 1.0*2.0 + 0.5*1.0 = 2.5 -> 0x28
      start_job(8'd2, 8'h00, 1'b0);
      send(8'h10, 8'h20, 1'b0);
      check("op_ready_mid", {15'd0, op_ready}, 16'd1);
      send(8'h08, 8'h10, 1'b0);
      wait_result(8'h28, 1'b0, 0, 1'b0);

      // T2: -1.0*1.0 with and without ReLU
      start_job(8'd1, 8'h00, 1'b1);
      send(8'hF0, 8'h10, 1'b0);
      wait_result(8'h00, 1'b0, 0, 1'b0);
      start_job(8'd1, 8'h00, 1'b0);
      send(8'hF0, 8'h10, 1'b0);
      wait_result(8'hF0, 1'b0, 0, 1'b0);

      // T3: 1.0 + bias 1.5 = 2.5; empty job yields bias 0.5
      start_job(8'd1, 8'h18, 1'b0);
      send(8'h10, 8'h10, 1'b0);
      wait_result(8'h28, 1'b0, 0, 1'b0);
      start_job(8'd0, 8'h08, 1'b0);
      wait_result(8'h08, 1'b0, 0, 1'b0);

      // T4: 4 * 16129 clamps to 0x7FFF
      for (int r = 0; r < 2; r++) begin
         start_job(8'd4, 8'h00, 1'(r));
         for (int i = 0; i < 4; i++) send(8'h7F, 8'h7F, 1'b0);
         wait_result((r == 0) ? 8'h7F : 8'hFF, 1'b1, 0, 1'b0);
      end

      // T5: random op_valid, stray starts, 5 cycles of res backpressure
      start_job(8'd2, 8'h00, 1'b0);
      send(8'h10, 8'h20, 1'b1);
      send(8'h08, 8'h10, 1'b1);
      wait_result(8'h28, 1'b0, 5, 1'b1);

      // T6: reset after one of three pairs, then a clean T1 job
      start_job(8'd3, 8'h00, 1'b0);
      send(8'h10, 8'h20, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_outputs", {11'd0, op_ready, res_valid, res_sat, busy, 1'b0}, 16'd0);
      check("rst_mid_data", {8'd0, res_data}, 16'd0);
      start_job(8'd2, 8'h00, 1'b0);
      send(8'h10, 8'h20, 1'b0);
      send(8'h08, 8'h10, 1'b0);
      wait_result(8'h28, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
